// File: rtl/bram_port_arbiter_pkg.sv
// ============================================================================
//  Module : bram_port_arbiter_pkg
//  Shared constants, requester ids and helpers for the BRAM port arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bram_port_arbiter_pkg;

  localparam int BRAM_DATA_WIDTH    = 32;
  localparam int DEFAULT_NREQ       = 4;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  // Fixed requester slots on the shared BRAM port
  typedef enum logic [2:0] {
    ARB_CPU = 3'd0,
    ARB_DMA = 3'd1,
    ARB_ETH = 3'd2
  } arbRequester_e;

  function automatic int wrapInc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_port_arbiter_rr_pick.sv
// ============================================================================
//  Module : rr_pick
//  Combinational round-robin picker: first eligible bit at or after ptr.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter int N     = DEFAULT_NREQ,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner,
  output logic [N-1:0]     oneHot
);

  logic [PTR_W-1:0] w_cand [N];

  // w_cand[k] is the requester index k positions after ptr, modulo N
  for (genvar k = 0; k < N; k++) begin : g_cand
    assign w_cand[k] = PTR_W'((int'(ptr) + k) % N);
  end

  // Scan from the far end so the candidate closest to ptr wins last
  always_comb begin
    any    = 1'b0;
    winner = '0;
    oneHot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[w_cand[k]]) begin
        any    = 1'b1;
        winner = w_cand[k];
      end
    end
    oneHot[winner] = any;
  end

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
//  Module : bram_port_arbiter
//  Round-robin sharing of one BRAM port between NREQ word-access masters.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ       = DEFAULT_NREQ,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                              Clock,
  input  logic                              ResetN,
  input  logic [NREQ-1:0]                   Req,
  input  logic [NREQ-1:0]                   Write,
  input  logic [NREQ*ADDR_WIDTH-1:0]        Addr,
  input  logic [NREQ*BRAM_DATA_WIDTH-1:0]   WData,
  output logic [NREQ-1:0]                   Ack,
  output logic [BRAM_DATA_WIDTH-1:0]        RData,
  output logic [BRAM_DATA_WIDTH-1:0]        BramAddress,
  output logic [BRAM_DATA_WIDTH-1:0]        BramDataIn,
  input  logic [BRAM_DATA_WIDTH-1:0]        BramDataOut,
  output logic                              BramClockEn,
  output logic                              BramWrite,
  output logic                              BramReset
);

  localparam int PTR_W = $clog2(NREQ);

  logic [ADDR_WIDTH-1:0]      w_addr  [NREQ];
  logic [BRAM_DATA_WIDTH-1:0] w_wdata [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_addr[i]  = Addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[i] = WData[i*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
  end

  logic [PTR_W-1:0]           r_ptr;
  logic [NREQ-1:0]            r_inflight;
  logic                       r_valid;
  logic [NREQ-1:0]            r_ack;
  logic                       r_bramClockEn;
  logic                       r_bramWrite;
  logic [BRAM_DATA_WIDTH-1:0] r_bramAddress;
  logic [BRAM_DATA_WIDTH-1:0] r_bramDataIn;

  logic [NREQ-1:0]  w_eligible;
  logic             w_any;
  logic [PTR_W-1:0] w_winner;
  logic [NREQ-1:0]  w_oneHot;
  logic [PTR_W-1:0] w_nextPtr;

  // A requester whose access is in the BRAM this cycle still holds Req;
  // masking it keeps the same request from being issued twice.
  assign w_eligible = Req & ~r_inflight;
  assign w_nextPtr  = PTR_W'(wrapInc(int'(w_winner), NREQ));

  rr_pick #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .any      (w_any),
    .winner   (w_winner),
    .oneHot   (w_oneHot)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_ptr         <= '0;
      r_inflight    <= '0;
      r_valid       <= 1'b0;
      r_ack         <= '0;
      r_bramClockEn <= 1'b0;
      r_bramWrite   <= 1'b0;
      r_bramAddress <= '0;
      r_bramDataIn  <= '0;
    end else begin
      r_ack         <= r_valid ? r_inflight : '0;
      r_valid       <= w_any;
      r_inflight    <= w_oneHot;
      r_bramClockEn <= w_any;
      if (w_any) begin
        r_bramWrite   <= Write[w_winner];
        r_bramAddress <= BRAM_DATA_WIDTH'(w_addr[w_winner]);
        r_bramDataIn  <= w_wdata[w_winner];
        r_ptr         <= w_nextPtr;
      end else begin
        r_bramWrite   <= 1'b0;
      end
    end
  end

  // BRAM DataOut is unregistered, so read data rides alongside the Ack
  assign RData       = BramDataOut;
  assign Ack         = r_ack;
  assign BramClockEn = r_bramClockEn;
  assign BramWrite   = r_bramWrite;
  assign BramAddress = r_bramAddress;
  assign BramDataIn  = r_bramDataIn;
  assign BramReset   = 1'b0;

endmodule

`default_nettype wire
